uart_fifo: RTL and testbench

- Next-generation serial port for the board-level host link.
- Generalises the fixed 8N1 UART with these compile-time settings:
  - character width
  - parity mode
  - stop-bit count
  - TX and RX FIFOs of configurable depth
- Adds per-frame error detection (parity, framing, overrun) and start-bit glitch rejection.
- Sits between the SIn/SOut pins and the CPU memory-mapped I/O block, using the same ready/valid handshakes.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_sync_fifo.sv | 58 +++++
 rtl/uart_fifo.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity modes, FSM state
// encodings and the baud divisor calculation.
`timescale 1ns/1ps
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } txState_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rxState_e;

   // Integer floor; the remainder is dropped, never accumulated.
   function automatic int calcDivisor(input int clockFreq, input int baudRate);
      return clockFreq / baudRate;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with an extra pointer bit so full and empty differ.
// The read head is combinational; a push into an empty FIFO shows next cycle.
`timescale 1ns/1ps
module uart_sync_fifo #(
   parameter int Width = 8,
   parameter int Depth = 8
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic [Width-1:0] pushData_i,
   input  logic             push_i,
   input  logic             pop_i,
   output logic [Width-1:0] popData_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AddrW = $clog2(Depth);
   localparam logic [AddrW:0] PtrOne = 1;

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW:0]   wrPtr_q, wrPtr_d;
   logic [AddrW:0]   rdPtr_q, rdPtr_d;
   logic             doPush;
   logic             doPop;

   assign empty_o = (wrPtr_q == rdPtr_q);
   assign full_o  = (wrPtr_q[AddrW] != rdPtr_q[AddrW]) &&
                    (wrPtr_q[AddrW-1:0] == rdPtr_q[AddrW-1:0]);

   // A pop frees the slot a simultaneous push into a full FIFO needs.
   assign doPop  = pop_i && !empty_o;
   assign doPush = push_i && (!full_o || pop_i);

   assign popData_o = mem_q[rdPtr_q[AddrW-1:0]];

   always_comb begin
      wrPtr_d = doPush ? wrPtr_q + PtrOne : wrPtr_q;
      rdPtr_d = doPop  ? rdPtr_q + PtrOne : rdPtr_q;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   always_ff @(posedge clock_i) begin
      if (doPush) begin
         mem_q[wrPtr_q[AddrW-1:0]] <= pushData_i;
      end
   end

endmodule

// File: rtl/uart_fifo.sv
// Configurable UART with TX/RX FIFOs, parity, framing and overrun detection
// and start-bit glitch rejection.
`timescale 1ns/1ps
module uart_fifo
   import uart_pkg::*;
#(
   parameter int ClockFreq = 50_000_000,
   parameter int BaudRate  = 115_200,
   parameter int DataBits  = 8,
   parameter int Parity    = 0,
   parameter int StopBits  = 1,
   parameter int FifoDepth = 8
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic [DataBits-1:0] DataIn,
   input  logic                DataInValid,
   output logic                DataInReady,
   output logic [DataBits-1:0] DataOut,
   output logic                DataOutValid,
   input  logic                DataOutReady,
   input  logic                SIn,
   output logic                SOut,
   output logic                ParityError,
   output logic                FrameError,
   output logic                Overrun,
   output logic                TxBusy
);

   localparam int Divisor = calcDivisor(ClockFreq, BaudRate);
   localparam int HalfDiv = Divisor / 2;
   localparam int StopLen = StopBits * Divisor;
   localparam int CntW    = $clog2(StopLen + 1);
   localparam int BitW    = $clog2(DataBits);

   localparam logic            OddPar     = (Parity == PARITY_ODD);
   localparam logic            HasPar     = (Parity != PARITY_NONE);
   localparam logic [CntW-1:0] CntOne     = CntW'(1);
   localparam logic [CntW-1:0] CntBitEnd  = CntW'(Divisor - 1);
   localparam logic [CntW-1:0] CntHalfEnd = CntW'(HalfDiv - 1);
   localparam logic [CntW-1:0] CntStopEnd = CntW'(StopLen - 1);
   localparam logic [BitW-1:0] LastBit    = BitW'(DataBits - 1);

   if (Divisor < 4) begin : gBadDivisor
      $error("uart_fifo: ClockFreq/BaudRate must be at least 4");
   end

   logic [DataBits-1:0] txHead;
   logic                txFull, txEmpty, txPop;
   logic                rxFull, rxEmpty;

   txState_e            txState_q, txState_d;
   logic [CntW-1:0]     txCnt_q, txCnt_d;
   logic [BitW-1:0]     txBit_q, txBit_d;
   logic [DataBits-1:0] txShift_q, txShift_d;
   logic                txParity_q, txParity_d;
   logic                sOut_q, sOut_d;

   rxState_e            rxState_q, rxState_d;
   logic [CntW-1:0]     rxCnt_q, rxCnt_d;
   logic [BitW-1:0]     rxBit_q, rxBit_d;
   logic [DataBits-1:0] rxShift_q, rxShift_d;
   logic                rxParBit_q, rxParBit_d;
   logic                rxPush_q, rxPush_d;
   logic                parErr_q, parErr_d;
   logic                frameErr_q, frameErr_d;
   logic                overrun_q, overrun_d;
   logic                sInMeta_q, sInSync_q, sInPrev_q;

   assign DataInReady  = !txFull && !Reset;
   assign DataOutValid = !rxEmpty;
   assign SOut         = sOut_q;
   assign TxBusy       = !txEmpty || (txState_q != TX_IDLE);
   assign ParityError  = parErr_q;
   assign FrameError   = frameErr_q;
   assign Overrun      = overrun_q;

   uart_sync_fifo #(.Width(DataBits), .Depth(FifoDepth)) uTxFifo (
      .clock_i    (Clock),
      .reset_i    (Reset),
      .pushData_i (DataIn),
      .push_i     (DataInValid && DataInReady),
      .pop_i      (txPop),
      .popData_o  (txHead),
      .full_o     (txFull),
      .empty_o    (txEmpty)
   );

   uart_sync_fifo #(.Width(DataBits), .Depth(FifoDepth)) uRxFifo (
      .clock_i    (Clock),
      .reset_i    (Reset),
      .pushData_i (rxShift_q),
      .push_i     (rxPush_q),
      .pop_i      (DataOutReady),
      .popData_o  (DataOut),
      .full_o     (rxFull),
      .empty_o    (rxEmpty)
   );

   // sOut_d is the line level for the state being entered, so the output
   // flop changes on the same edge as the state register.
   always_comb begin
      txState_d  = txState_q;
      txCnt_d    = txCnt_q + CntOne;
      txBit_d    = txBit_q;
      txShift_d  = txShift_q;
      txParity_d = txParity_q;
      sOut_d     = sOut_q;
      txPop      = 1'b0;
      case (txState_q)
         TX_IDLE: begin
            txCnt_d = '0;
            sOut_d  = 1'b1;
            if (!txEmpty) begin
               txState_d  = TX_START;
               txPop      = 1'b1;
               txShift_d  = txHead;
               txParity_d = (^txHead) ^ OddPar;
               sOut_d     = 1'b0;
            end
         end
         TX_START: begin
            if (txCnt_q == CntBitEnd) begin
               txState_d = TX_DATA;
               txCnt_d   = '0;
               txBit_d   = '0;
               sOut_d    = txShift_q[0];
            end
         end
         TX_DATA: begin
            if (txCnt_q == CntBitEnd) begin
               txCnt_d = '0;
               if (txBit_q == LastBit) begin
                  txState_d = HasPar ? TX_PARITY : TX_STOP;
                  sOut_d    = HasPar ? txParity_q : 1'b1;
               end else begin
                  txBit_d   = txBit_q + 1'b1;
                  txShift_d = txShift_q >> 1;
                  sOut_d    = txShift_q[1];
               end
            end
         end
         TX_PARITY: begin
            if (txCnt_q == CntBitEnd) begin
               txState_d = TX_STOP;
               txCnt_d   = '0;
               sOut_d    = 1'b1;
            end
         end
         TX_STOP: begin
            if (txCnt_q == CntStopEnd) begin
               txCnt_d = '0;
               if (!txEmpty) begin
                  txState_d  = TX_START;
                  txPop      = 1'b1;
                  txShift_d  = txHead;
                  txParity_d = (^txHead) ^ OddPar;
                  sOut_d     = 1'b0;
               end else begin
                  txState_d = TX_IDLE;
                  sOut_d    = 1'b1;
               end
            end
         end
         default: begin
            txState_d = TX_IDLE;
            sOut_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         txState_q  <= TX_IDLE;
         txCnt_q    <= '0;
         txBit_q    <= '0;
         txShift_q  <= '0;
         txParity_q <= 1'b0;
         sOut_q     <= 1'b1;
      end else begin
         txState_q  <= txState_d;
         txCnt_q    <= txCnt_d;
         txBit_q    <= txBit_d;
         txShift_q  <= txShift_d;
         txParity_q <= txParity_d;
         sOut_q     <= sOut_d;
      end
   end

   // Only the first stop bit is sampled; returning to idle right after it
   // lets a start bit one bit-time later be caught.
   always_comb begin
      rxState_d  = rxState_q;
      rxCnt_d    = rxCnt_q + CntOne;
      rxBit_d    = rxBit_q;
      rxShift_d  = rxShift_q;
      rxParBit_d = rxParBit_q;
      rxPush_d   = 1'b0;
      parErr_d   = 1'b0;
      frameErr_d = 1'b0;
      overrun_d  = 1'b0;
      case (rxState_q)
         RX_IDLE: begin
            rxCnt_d = '0;
            if (sInPrev_q && !sInSync_q) begin
               rxState_d = RX_START;
            end
         end
         RX_START: begin
            if (rxCnt_q == CntHalfEnd) begin
               rxCnt_d = '0;
               if (sInSync_q) begin
                  rxState_d = RX_IDLE;
               end else begin
                  rxState_d = RX_DATA;
                  rxBit_d   = '0;
               end
            end
         end
         RX_DATA: begin
            if (rxCnt_q == CntBitEnd) begin
               rxCnt_d   = '0;
               rxShift_d = {sInSync_q, rxShift_q[DataBits-1:1]};
               if (rxBit_q == LastBit) begin
                  rxState_d = HasPar ? RX_PARITY : RX_STOP;
               end else begin
                  rxBit_d = rxBit_q + 1'b1;
               end
            end
         end
         RX_PARITY: begin
            if (rxCnt_q == CntBitEnd) begin
               rxState_d  = RX_STOP;
               rxCnt_d    = '0;
               rxParBit_d = sInSync_q;
            end
         end
         RX_STOP: begin
            if (rxCnt_q == CntBitEnd) begin
               rxState_d = RX_IDLE;
               rxCnt_d   = '0;
               if (!sInSync_q) begin
                  frameErr_d = 1'b1;
               end else if (HasPar && (rxParBit_q != ((^rxShift_q) ^ OddPar))) begin
                  parErr_d = 1'b1;
               end else if (rxFull) begin
                  overrun_d = 1'b1;
               end else begin
                  rxPush_d = 1'b1;
               end
            end
         end
         default: rxState_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sInMeta_q  <= 1'b1;
         sInSync_q  <= 1'b1;
         sInPrev_q  <= 1'b1;
         rxState_q  <= RX_IDLE;
         rxCnt_q    <= '0;
         rxBit_q    <= '0;
         rxShift_q  <= '0;
         rxParBit_q <= 1'b0;
         rxPush_q   <= 1'b0;
         parErr_q   <= 1'b0;
         frameErr_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         sInMeta_q  <= SIn;
         sInSync_q  <= sInMeta_q;
         sInPrev_q  <= sInSync_q;
         rxState_q  <= rxState_d;
         rxCnt_q    <= rxCnt_d;
         rxBit_q    <= rxBit_d;
         rxShift_q  <= rxShift_d;
         rxParBit_q <= rxParBit_d;
         rxPush_q   <= rxPush_d;
         parErr_q   <= parErr_d;
         frameErr_q <= frameErr_d;
         overrun_q  <= overrun_d;
      end
   end

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: divisor 10, 8 data bits, even parity,
// two stop bits, 8-entry FIFOs.
`timescale 1ns/1ps
module tb_uart_fifo;

   localparam int ClockFreq = 1_000_000;
   localparam int BaudRate  = 100_000;
   localparam int DataBits  = 8;
   localparam int Parity    = 2;
   localparam int StopBits  = 2;
   localparam int FifoDepth = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] dataIn = 8'h00;
   logic       dataInValid = 1'b0;
   logic       dataInReady;
   logic [7:0] dataOut;
   logic       dataOutValid;
   logic       dataOutReady = 1'b0;
   logic       sInDrive = 1'b1;
   logic       loopback = 1'b0;
   logic       sInLine;
   logic       sOut;
   logic       parityError, frameError, overrun, txBusy;

   int checks = 0;
   int errors = 0;
   int parCnt = 0;
   int frameCnt = 0;
   int ovrCnt = 0;

   assign sInLine = loopback ? sOut : sInDrive;

   always #5 clock = ~clock;

   uart_fifo #(
      .ClockFreq (ClockFreq),
      .BaudRate  (BaudRate),
      .DataBits  (DataBits),
      .Parity    (Parity),
      .StopBits  (StopBits),
      .FifoDepth (FifoDepth)
   ) dut (
      .Clock        (clock),
      .Reset        (reset),
      .DataIn       (dataIn),
      .DataInValid  (dataInValid),
      .DataInReady  (dataInReady),
      .DataOut      (dataOut),
      .DataOutValid (dataOutValid),
      .DataOutReady (dataOutReady),
      .SIn          (sInLine),
      .SOut         (sOut),
      .ParityError  (parityError),
      .FrameError   (frameError),
      .Overrun      (overrun),
      .TxBusy       (txBusy)
   );

   // Count the cycles each error pulse is high.
   always @(negedge clock) begin
      if (parityError) parCnt++;
      if (frameError)  frameCnt++;
      if (overrun)     ovrCnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives one serial frame on the RX pin, followed by two idle bit-times.
   task automatic applyStimulus(input logic [7:0] d, input logic parBit, input logic stopBit);
      sInDrive = 1'b0;
      tick(10);
      for (int i = 0; i < 8; i++) begin
         sInDrive = d[i];
         tick(10);
      end
      sInDrive = parBit;
      tick(10);
      sInDrive = stopBit;
      tick(10);
      sInDrive = 1'b1;
      tick(20);
   endtask

   task automatic popExpect(input string tag, input logic [7:0] exp, input int budget);
      int n;
      n = 0;
      while (!dataOutValid && n < budget) begin
         tick(1);
         n++;
      end
      checkOutput({tag, " valid"}, {31'd0, dataOutValid}, 32'd1);
      checkOutput(tag, {24'd0, dataOut}, {24'd0, exp});
      dataOutReady = 1'b1;
      tick(1);
      dataOutReady = 1'b0;
   endtask

   task automatic waitTxIdle(input string tag, input int budget);
      int n;
      n = 0;
      while (txBusy && n < budget) begin
         tick(1);
         n++;
      end
      checkOutput(tag, {31'd0, txBusy}, 32'd0);
   endtask

   initial begin
      logic [7:0] txByte;
      logic [7:0] burst [4];
      int         errBase;

      // Reset state
      tick(3);
      checkOutput("reset sout", {31'd0, sOut}, 32'd1);
      checkOutput("reset ready", {31'd0, dataInReady}, 32'd0);
      checkOutput("reset outvalid", {31'd0, dataOutValid}, 32'd0);
      checkOutput("reset txbusy", {31'd0, txBusy}, 32'd0);
      checkOutput("reset pulses", {29'd0, parityError, frameError, overrun}, 32'd0);
      reset = 1'b0;
      tick(1);
      checkOutput("ready after reset", {31'd0, dataInReady}, 32'd1);

      // Single TX byte 0xA5
      txByte = 8'hA5;
      dataIn = txByte;
      dataInValid = 1'b1;
      tick(1);
      dataInValid = 1'b0;
      checkOutput("tx still idle +1", {31'd0, sOut}, 32'd1);
      tick(1);
      checkOutput("tx start +2", {31'd0, sOut}, 32'd0);
      checkOutput("tx busy", {31'd0, txBusy}, 32'd1);
      tick(5);
      checkOutput("tx start mid", {31'd0, sOut}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick(10);
         checkOutput($sformatf("tx bit%0d", i), {31'd0, sOut}, {31'd0, txByte[i]});
      end
      tick(10);
      checkOutput("tx parity", {31'd0, sOut}, 32'd0);
      tick(10);
      checkOutput("tx stop1", {31'd0, sOut}, 32'd1);
      tick(10);
      checkOutput("tx stop2", {31'd0, sOut}, 32'd1);
      tick(4);
      checkOutput("tx busy end of stop", {31'd0, txBusy}, 32'd1);
      tick(1);
      checkOutput("tx busy drops", {31'd0, txBusy}, 32'd0);

      // Loopback burst
      loopback = 1'b1;
      errBase = parCnt + frameCnt + ovrCnt;
      burst = '{8'h00, 8'hFF, 8'h3C, 8'h81};
      for (int i = 0; i < 4; i++) begin
         dataIn = burst[i];
         dataInValid = 1'b1;
         tick(1);
      end
      dataInValid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         popExpect($sformatf("loop byte%0d", i), burst[i], 400);
      end
      waitTxIdle("loop tx idle", 200);
      checkOutput("loop no pulses", parCnt + frameCnt + ovrCnt - errBase, 32'd0);
      loopback = 1'b0;

      // TX FIFO fills after 8+1 pushes with no drain
      for (int i = 0; i < 9; i++) begin
         dataIn = 8'(i + 1);
         dataInValid = 1'b1;
         checkOutput($sformatf("fill ready%0d", i), {31'd0, dataInReady}, 32'd1);
         tick(1);
      end
      dataInValid = 1'b0;
      checkOutput("fill full", {31'd0, dataInReady}, 32'd0);
      waitTxIdle("fill drain", 2000);
      checkOutput("fill ready again", {31'd0, dataInReady}, 32'd1);

      // RX parity error
      errBase = parCnt;
      applyStimulus(8'h55, 1'b1, 1'b1);
      checkOutput("parity pulse", parCnt - errBase, 32'd1);
      checkOutput("parity no data", {31'd0, dataOutValid}, 32'd0);

      // RX framing error
      errBase = frameCnt;
      applyStimulus(8'h0F, 1'b0, 1'b0);
      checkOutput("frame pulse", frameCnt - errBase, 32'd1);
      checkOutput("frame no data", {31'd0, dataOutValid}, 32'd0);

      // Start-bit glitch then a valid 0x12
      errBase = parCnt + frameCnt + ovrCnt;
      sInDrive = 1'b0;
      tick(3);
      sInDrive = 1'b1;
      tick(30);
      checkOutput("glitch no pulse", parCnt + frameCnt + ovrCnt - errBase, 32'd0);
      checkOutput("glitch no data", {31'd0, dataOutValid}, 32'd0);
      applyStimulus(8'h12, 1'b0, 1'b1);
      popExpect("after glitch", 8'h12, 50);

      // Overrun: nine frames into an undrained FIFO
      errBase = parCnt + frameCnt;
      begin
         int ovrBase;
         ovrBase = ovrCnt;
         for (int i = 0; i < 9; i++) begin
            txByte = 8'(8'h10 + i);
            applyStimulus(txByte, ^txByte, 1'b1);
         end
         checkOutput("overrun pulse", ovrCnt - ovrBase, 32'd1);
      end
      checkOutput("overrun other pulses", parCnt + frameCnt - errBase, 32'd0);
      for (int i = 0; i < 8; i++) begin
         popExpect($sformatf("overrun pop%0d", i), 8'(8'h10 + i), 10);
      end
      checkOutput("overrun drained", {31'd0, dataOutValid}, 32'd0);

      // Reset mid-frame: TX bit 3 of 0xC3, RX bit 4, one byte parked in RX FIFO
      applyStimulus(8'h77, ^8'h77, 1'b1);
      checkOutput("parked byte", {31'd0, dataOutValid}, 32'd1);
      txByte = 8'hC3;
      sInDrive = 1'b0;
      tick(8);
      dataIn = txByte;
      dataInValid = 1'b1;
      tick(1);
      dataInValid = 1'b0;
      tick(1);
      sInDrive = 1'b1;
      tick(10);
      sInDrive = 1'b0;
      tick(10);
      sInDrive = 1'b1;
      tick(10);
      sInDrive = 1'b0;
      tick(10);
      sInDrive = 1'b1;
      tick(5);
      checkOutput("mid tx bit3", {31'd0, sOut}, 32'd0);
      reset = 1'b1;
      sInDrive = 1'b1;
      tick(1);
      checkOutput("midreset sout", {31'd0, sOut}, 32'd1);
      checkOutput("midreset outvalid", {31'd0, dataOutValid}, 32'd0);
      checkOutput("midreset txbusy", {31'd0, txBusy}, 32'd0);
      reset = 1'b0;
      errBase = parCnt + frameCnt + ovrCnt;
      tick(30);
      checkOutput("post reset idle", {30'd0, txBusy, dataOutValid}, 32'd0);
      applyStimulus(8'h5A, ^8'h5A, 1'b1);
      checkOutput("post reset no pulses", parCnt + frameCnt + ovrCnt - errBase, 32'd0);
      popExpect("post reset byte", 8'h5A, 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
